// File: rtl/pipe_pkg.sv
// Shared slot indices and register-index type for the pipeline controller.
package pipe_pkg;
    localparam int SLOT_IF  = 0;
    localparam int SLOT_ID  = 1;
    localparam int SLOT_EX  = 2;
    localparam int SLOT_MEM = 3;
    localparam int SLOT_WB  = 4;

    localparam int REGW = 5;
    typedef logic [REGW-1:0] reg_idx_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Control/status bundle between the datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
    parameter int NSTAGE = 5,
    parameter int PCW    = 32
);
    logic [PCW-1:0]       fetch_pc;
    pipe_pkg::reg_idx_t   id_rs, id_rt;
    logic                 id_use_rs, id_use_rt;
    logic                 lu_memrd, lu_regwr;
    pipe_pkg::reg_idx_t   lu_wrreg;
    logic                 redirect, mem_wait, irq, eret;

    logic [NSTAGE-1:0]    adv;
    logic [NSTAGE-1:0]    valid;
    logic                 pc_hold, flush_young, irq_take, irq_en;
    logic [PCW-1:0]       epc;
    logic [15:0]          stall_cnt;

    modport master (
        output fetch_pc, id_rs, id_rt, id_use_rs, id_use_rt,
               lu_memrd, lu_regwr, lu_wrreg, redirect, mem_wait, irq, eret,
        input  adv, valid, pc_hold, flush_young, irq_take, epc, irq_en, stall_cnt
    );
    modport slave (
        input  fetch_pc, id_rs, id_rt, id_use_rs, id_use_rt,
               lu_memrd, lu_regwr, lu_wrreg, redirect, mem_wait, irq, eret,
        output adv, valid, pc_hold, flush_young, irq_take, epc, irq_en, stall_cnt
    );
endinterface

// File: rtl/pipe_lu_detect.sv
// Load-use hazard compare: a pending load feeds a source the resolve slot reads.
module pipe_lu_detect
    import pipe_pkg::*;
(
    input  logic     i_lu_valid,
    input  logic     i_memrd,
    input  logic     i_regwr,
    input  reg_idx_t i_wrreg,
    input  logic     i_id_valid,
    input  reg_idx_t i_rs,
    input  reg_idx_t i_rt,
    input  logic     i_use_rs,
    input  logic     i_use_rt,
    output logic     o_stall
);
    logic w_hit;

    assign w_hit   = (i_use_rs && (i_rs == i_wrreg)) || (i_use_rt && (i_rt == i_wrreg));
    // $0 is hard-wired, so a load targeting it never creates a hazard
    assign o_stall = i_lu_valid && i_memrd && i_regwr && (i_wrreg != '0) && i_id_valid && w_hit;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush/interrupt controller: per-slot valid and PC tracking,
// stall and bubble generation, redirect flush and interrupt entry/return.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NSTAGE  = 5,
    parameter int RESOLVE = SLOT_ID,
    parameter int LU_SLOT = SLOT_EX,
    parameter int FREEZE  = NSTAGE - 2,
    parameter int PCW     = 32
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    logic [NSTAGE-1:0]          w_valid;
    logic [NSTAGE-1:0][PCW-1:0] w_pc;
    logic [NSTAGE-1:0]          w_adv;
    logic [PCW-1:0]             r_epc;
    logic                       r_irq_en;
    logic [15:0]                r_stall_cnt;
    logic                       w_lu_stall, w_stall, w_irq_take, w_redir;

    pipe_lu_detect u_lu (
        .i_lu_valid (w_valid[LU_SLOT]),
        .i_memrd    (bus.lu_memrd),
        .i_regwr    (bus.lu_regwr),
        .i_wrreg    (bus.lu_wrreg),
        .i_id_valid (w_valid[RESOLVE]),
        .i_rs       (bus.id_rs),
        .i_rt       (bus.id_rt),
        .i_use_rs   (bus.id_use_rs),
        .i_use_rt   (bus.id_use_rt),
        .o_stall    (w_lu_stall)
    );

    assign w_stall    = bus.mem_wait || w_lu_stall;
    assign w_irq_take = !reset && bus.irq && r_irq_en && w_valid[RESOLVE] && !w_stall;
    assign w_redir    = !reset && bus.redirect && w_valid[RESOLVE] && !w_stall && !w_irq_take;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_slot
        localparam bit HOLD_MW = (k <= FREEZE);
        localparam bit HOLD_LU = (k <= RESOLVE);
        localparam bit BUB_MW  = (k == FREEZE + 1);
        localparam bit BUB_LU  = (k == RESOLVE + 1);
        localparam bit KILL_IQ = (k <= RESOLVE + 1);
        localparam bit KILL_RD = (k <= RESOLVE);

        logic           r_v;
        logic [PCW-1:0] r_p;
        logic           w_prev_v, w_kill;
        logic [PCW-1:0] w_prev_pc;

        if (k == 0) begin : g_head
            assign w_prev_v  = 1'b1;
            assign w_prev_pc = bus.fetch_pc;
        end else begin : g_body
            assign w_prev_v  = w_valid[k-1];
            assign w_prev_pc = w_pc[k-1];
        end

        // mem_wait freezes the front up to FREEZE; a load-use stall only up to RESOLVE
        assign w_adv[k] = reset || !((bus.mem_wait && HOLD_MW) ||
                                     (!bus.mem_wait && w_lu_stall && HOLD_LU));

        assign w_kill = (bus.mem_wait && BUB_MW) ||
                        (!bus.mem_wait && w_lu_stall && BUB_LU) ||
                        (w_irq_take && KILL_IQ) ||
                        (w_redir && KILL_RD);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_v <= 1'b0;
                r_p <= '0;
            end else if (w_adv[k]) begin
                r_v <= w_prev_v && !w_kill;
                r_p <= w_prev_pc;
            end
        end

        assign w_valid[k] = r_v;
        assign w_pc[k]    = r_p;
    end

    // interrupt entry wins over a same-cycle eret
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc       <= '0;
            r_irq_en    <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            if (w_irq_take) begin
                r_epc    <= w_pc[RESOLVE];
                r_irq_en <= 1'b0;
            end else if (bus.eret && w_valid[RESOLVE] && !w_stall) begin
                r_irq_en <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.adv         = w_adv;
    assign bus.valid       = w_valid;
    assign bus.pc_hold     = !reset && w_stall;
    assign bus.flush_young = w_redir;
    assign bus.irq_take    = w_irq_take;
    assign bus.epc         = r_epc;
    assign bus.irq_en      = r_irq_en;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: combinational vector table plus multi-cycle sequences.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl_if #(.NSTAGE(5), .PCW(32)) bus ();

    pipe_ctrl #(.NSTAGE(5), .RESOLVE(1), .LU_SLOT(2), .FREEZE(3), .PCW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       memrd, regwr;
        logic [4:0] wrreg, rs, rt;
        logic       use_rs, use_rt, redirect, mem_wait, irq;
        logic [4:0] adv;
        logic       hold, flush, irqt;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic memrd, logic regwr, logic [4:0] wrreg, logic [4:0] rs,
                                logic [4:0] rt, logic use_rs, logic use_rt, logic redirect,
                                logic mem_wait, logic irq, logic [4:0] adv, logic hold,
                                logic flush, logic irqt);
        vec_t v;
        v = '{memrd, regwr, wrreg, rs, rt, use_rs, use_rt, redirect, mem_wait, irq,
              adv, hold, flush, irqt};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.lu_memrd = 0; bus.lu_regwr = 0; bus.lu_wrreg = 0;
        bus.redirect = 0; bus.mem_wait = 0; bus.irq = 0; bus.eret = 0;
    endtask

    task automatic set_lu();
        bus.lu_memrd = 1; bus.lu_regwr = 1; bus.lu_wrreg = 5'd8;
        bus.id_rs = 5'd8; bus.id_use_rs = 1;
    endtask

    task automatic apply(input vec_t v);
        bus.lu_memrd = v.memrd; bus.lu_regwr = v.regwr; bus.lu_wrreg = v.wrreg;
        bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_use_rs = v.use_rs; bus.id_use_rt = v.use_rt;
        bus.redirect = v.redirect; bus.mem_wait = v.mem_wait; bus.irq = v.irq;
    endtask

    initial begin
        tbl[0]  = mk(0,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,0);
        tbl[1]  = mk(1,1,8,8,0,1,0,0,0,0, 5'b11100,1,0,0);
        tbl[2]  = mk(1,1,8,8,0,0,0,0,0,0, 5'b11111,0,0,0);
        tbl[3]  = mk(1,1,8,0,8,0,1,0,0,0, 5'b11100,1,0,0);
        tbl[4]  = mk(1,1,0,0,0,1,1,0,0,0, 5'b11111,0,0,0);
        tbl[5]  = mk(0,1,8,8,0,1,0,0,0,0, 5'b11111,0,0,0);
        tbl[6]  = mk(1,0,8,8,0,1,0,0,0,0, 5'b11111,0,0,0);
        tbl[7]  = mk(1,1,9,8,9,1,1,0,0,0, 5'b11100,1,0,0);
        tbl[8]  = mk(1,1,9,9,8,0,1,0,0,0, 5'b11111,0,0,0);
        tbl[9]  = mk(0,0,0,0,0,0,0,1,0,0, 5'b11111,0,1,0);
        tbl[10] = mk(1,1,8,8,0,1,0,1,0,0, 5'b11100,1,0,0);
        tbl[11] = mk(0,0,0,0,0,0,0,0,1,0, 5'b10000,1,0,0);
        tbl[12] = mk(0,0,0,0,0,0,0,1,1,1, 5'b10000,1,0,0);
        tbl[13] = mk(0,0,0,0,0,0,0,0,0,1, 5'b11111,0,0,1);
        tbl[14] = mk(0,0,0,0,0,0,0,1,0,1, 5'b11111,0,0,1);
        tbl[15] = mk(1,1,8,8,0,1,0,0,0,1, 5'b11100,1,0,0);
        tbl[16] = mk(1,1,8,8,0,1,0,0,1,0, 5'b10000,1,0,0);

        // reset with hostile inputs: outputs must still show the reset values
        idle();
        bus.fetch_pc = 32'h1234;
        bus.mem_wait = 1; bus.irq = 1; bus.redirect = 1;
        tick(); tick();
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_adv", 32'(bus.adv), 32'h1f);
        chk("rst_pc_hold", 32'(bus.pc_hold), 0);
        chk("rst_flush", 32'(bus.flush_young), 0);
        chk("rst_irq_take", 32'(bus.irq_take), 0);
        chk("rst_epc", bus.epc, 0);
        chk("rst_irq_en", 32'(bus.irq_en), 1);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        chk("rst_pc4", dut.w_pc[4], 0);

        // release and fill
        idle();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            bus.fetch_pc = 32'h1000 + 32'(4 * i);
            tick();
            if (i == 0) begin
                chk("fill_first_valid", 32'(bus.valid), 32'h01);
                chk("fill_first_pc0", dut.w_pc[0], 32'h1000);
            end
        end
        chk("fill_valid", 32'(bus.valid), 32'h1f);
        chk("fill_pc4", dut.w_pc[4], 32'h1000);

        // combinational vector table, never clocked with a row applied
        for (int i = 0; i < 17; i++) begin
            tick();
            apply(tbl[i]);
            #1;
            chk($sformatf("vec%0d_adv", i), 32'(bus.adv), 32'(tbl[i].adv));
            chk($sformatf("vec%0d_hold", i), 32'(bus.pc_hold), 32'(tbl[i].hold));
            chk($sformatf("vec%0d_flush", i), 32'(bus.flush_young), 32'(tbl[i].flush));
            chk($sformatf("vec%0d_irq_take", i), 32'(bus.irq_take), 32'(tbl[i].irqt));
            idle();
        end
        chk("tbl_valid_after", 32'(bus.valid), 32'h1f);
        chk("tbl_stall_cnt", 32'(bus.stall_cnt), 0);

        // load-use: one stall cycle, bubble into slot 2
        set_lu();
        bus.fetch_pc = 32'h2000;
        #1;
        chk("lu_adv", 32'(bus.adv), 32'h1c);
        tick();
        idle();
        chk("lu_valid", 32'(bus.valid), 32'h1b);
        chk("lu_pc0_held", dut.w_pc[0], 32'h1010);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 1);

        // redirect with ID pc=0x40
        bus.fetch_pc = 32'h40; tick();
        bus.fetch_pc = 32'h44; tick();
        bus.redirect = 1;
        #1;
        chk("redir_flush", 32'(bus.flush_young), 1);
        tick();
        bus.redirect = 0;
        chk("redir_valid", 32'(bus.valid), 32'h1c);
        chk("redir_pc2", dut.w_pc[2], 32'h40);
        chk("redir_flush_off", 32'(bus.flush_young), 0);

        // irq beats redirect with ID pc=0x80
        bus.fetch_pc = 32'h80; tick();
        bus.fetch_pc = 32'h84; tick();
        bus.irq = 1; bus.redirect = 1;
        #1;
        chk("irq_take", 32'(bus.irq_take), 1);
        chk("irq_no_flush", 32'(bus.flush_young), 0);
        tick();
        bus.redirect = 0;
        chk("irq_epc", bus.epc, 32'h80);
        chk("irq_en_clr", 32'(bus.irq_en), 0);
        chk("irq_valid_lo", 32'(bus.valid[2:0]), 0);
        tick(); tick();
        chk("irq_masked", 32'(bus.irq_take), 0);
        bus.irq = 0; bus.eret = 1;
        tick();
        bus.eret = 0;
        chk("eret_irq_en", 32'(bus.irq_en), 1);
        chk("eret_epc_kept", bus.epc, 32'h80);
        bus.irq = 1;
        #1;
        chk("irq_after_eret", 32'(bus.irq_take), 1);
        bus.irq = 0;
        repeat (5) tick();
        chk("refill_valid", 32'(bus.valid), 32'h1f);

        // mem_wait for three cycles with a pending irq
        bus.mem_wait = 1; bus.irq = 1; bus.fetch_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw%0d_irq_take", i), 32'(bus.irq_take), 0);
            chk($sformatf("mw%0d_adv", i), 32'(bus.adv), 32'h10);
            tick();
            chk($sformatf("mw%0d_valid", i), 32'(bus.valid), 32'h0f);
            chk($sformatf("mw%0d_pc0", i), dut.w_pc[0], 32'h84);
        end
        bus.mem_wait = 0;
        #1;
        chk("mw_stall_cnt", 32'(bus.stall_cnt), 4);
        chk("mw_irq_after", 32'(bus.irq_take), 1);
        bus.irq = 0;

        // asynchronous reset in the middle of a stall
        tick();
        bus.mem_wait = 1;
        set_lu();
        tick();
        reset = 1;
        #1;
        chk("arst_valid", 32'(bus.valid), 0);
        chk("arst_stall_cnt", 32'(bus.stall_cnt), 0);
        chk("arst_adv", 32'(bus.adv), 32'h1f);
        chk("arst_pc_hold", 32'(bus.pc_hold), 0);
        chk("arst_irq_en", 32'(bus.irq_en), 1);
        tick();
        idle();
        reset = 0;
        tick();
        chk("arst_release_valid", 32'(bus.valid), 32'h01);

        // stall counter saturation
        bus.mem_wait = 1;
        repeat (65534) tick();
        chk("sat_fffe", 32'(bus.stall_cnt), 32'hfffe);
        tick();
        chk("sat_ffff", 32'(bus.stall_cnt), 32'hffff);
        repeat (4500) tick();
        chk("sat_hold", 32'(bus.stall_cnt), 32'hffff);
        bus.mem_wait = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, meaning pipeline slot count; slot 0=IF, 1=ID, 2=EX, 3=MEM, NSTAGE-1=WB.
REQ-002 SHALL have parameter RESOLVE, default 1, meaning slot where branches and interrupts resolve; legal range 1..NSTAGE-3.
REQ-003 SHALL have parameter LU_SLOT, default 2, meaning slot holding a load whose result is not yet forwardable.
REQ-004 SHALL have parameter FREEZE, default NSTAGE-2, meaning the highest slot frozen by mem_wait.
REQ-005 SHALL have parameter PCW, default 32, meaning PC width.
REQ-006 SHALL have clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-007 SHALL have reset  input  1  meaning asynchronous, active-high reset.
REQ-008 SHALL have fetch_pc  input  PCW  meaning the PC being fetched this cycle.
REQ-009 SHALL have id_rs, id_rt  input  5 each  meaning the source registers of the instruction in slot RESOLVE.
REQ-010 SHALL have id_use_rs, id_use_rt  input  1 each  meaning the corresponding source register is actually read.
REQ-011 SHALL have lu_memrd, lu_regwr  input  1 each, and lu_wrreg  input  5, meaning the control of the instruction in slot LU_SLOT.
REQ-012 SHALL have redirect  input  1  meaning a taken branch or jump in slot RESOLVE.
REQ-013 SHALL have mem_wait  input  1  meaning the memory stage is busy.
REQ-014 SHALL have irq  input  1  meaning a level interrupt request.
REQ-015 SHALL have eret  input  1  meaning an exception return was executed in slot RESOLVE.
REQ-016 SHALL have the following outputs:
- adv  output  NSTAGE  meaning per-slot register load enable.
- valid  output  NSTAGE  meaning per-slot instruction valid.
- pc_hold  output  1  meaning hold the PC register.
- flush_young  output  1  meaning a redirect was accepted.
- irq_take  output  1  meaning an interrupt was accepted.
- epc  output  PCW  meaning the exception return PC.
- irq_en  output  1  meaning interrupts are enabled.
- stall_cnt  output  16  meaning stall-cycle count.

Function
REQ-017 SHALL track valid[k] and pc[k] for every slot; when a slot advances it SHALL copy slot k-1 (slot 0 copies fetch_pc with valid=1).
REQ-018 SHALL assert lu_stall when all of the following hold:
- valid[LU_SLOT], lu_memrd and lu_regwr are set;
- lu_wrreg is not 0;
- valid[RESOLVE] is set;
- lu_wrreg equals a used id_rs or id_rt.
REQ-019 SHALL, on mem_wait (highest priority), hold slots 0..FREEZE and pc_hold, load a bubble (valid=0) into slot FREEZE+1, and let slots above FREEZE+1 advance.
REQ-020 SHALL, on lu_stall without mem_wait, hold slots 0..RESOLVE and pc_hold, load a bubble into slot RESOLVE+1, and let older slots advance.
REQ-021 SHALL accept a redirect only when redirect, valid[RESOLVE], !lu_stall, !mem_wait and !irq_take all hold. On acceptance it SHALL:
- pulse flush_young for one cycle;
- load valid=0 into slots 0..RESOLVE.
The accepted instruction SHALL still advance to slot RESOLVE+1.
REQ-022 SHALL assert irq_take (combinational, one cycle) when all of the following hold: irq, irq_en, valid[RESOLVE], !lu_stall and !mem_wait. On irq_take it SHALL:
- load epc <= pc[RESOLVE];
- clear irq_en;
- load valid=0 into slots 0..RESOLVE+1, so the interrupted instruction is discarded and re-executed after return.
REQ-023 SHALL give irq_take priority over a simultaneous redirect; epc then equals the branch PC.
REQ-024 SHALL set irq_en on an eret whose slot is valid and not stalled; an eret in the same cycle as irq_take SHALL be ignored.
REQ-025 SHALL otherwise set adv to all ones with pc_hold=0.
REQ-026 SHALL increment stall_cnt each cycle in which mem_wait or lu_stall is set, saturating at 16'hFFFF.
REQ-027 SHALL generate valid and adv for any NSTAGE>=4 with no per-slot hand-written logic.

Reset
REQ-028 SHALL, while reset=1 and regardless of clk, force valid=0, pc[*]=0, epc=0, irq_en=1 and stall_cnt=0.
REQ-029 SHALL drive adv=all ones, pc_hold=0, flush_young=0 and irq_take=0 while reset is asserted.
REQ-030 SHALL, on a reset asserted mid-stall or mid-flush, discard all pending state; the first edge after release SHALL make valid[0]=1.

Structure
REQ-031 SHALL place the default slot-index constants (IF, ID, EX, MEM, WB) and the register-index width in shared package pipe_pkg.
REQ-032 SHALL implement the load-use compare as the single combinational sub-module pipe_lu_detect.

Verification
REQ-033 SHALL cover reset release: after 5 clocks with no events, valid=5'b11111 and pc[4] equals the fetch_pc sampled 4 cycles earlier.
REQ-034 SHALL cover load-use: LU slot holds lw to $8, ID reads rs=$8 -> one cycle with adv[1:0]=0, valid[2]=0 next, stall_cnt +1.
REQ-035 SHALL cover redirect: redirect with ID pc=0x40 -> flush_young=1, next cycle valid[1:0]=0 and pc[2]=0x40.
REQ-036 SHALL cover irq plus redirect on the same cycle with ID pc=0x80 -> irq_take=1, flush_young=0, epc=0x80, irq_en=0; a further irq is ignored until eret, after which irq_en=1.
REQ-037 SHALL cover mem_wait held 3 cycles -> slots 0..3 frozen, valid[4]=0 for 3 cycles, stall_cnt +3; irq during the wait SHALL not be taken until it drops.
REQ-038 SHALL cover saturation: 70000 forced stall cycles -> stall_cnt=16'hFFFF and stays there.
